// File: rtl/booth_vote_arbiter_pkg.sv
// Shared definitions for the booth vote arbiter: FSM encoding, code and count limits.
package booth_vote_arbiter_pkg;

  localparam int unsigned STATE_W = 2;
  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] S_ACK   = 2'd2;
  localparam logic [STATE_W-1:0] S_REJ   = 2'd3;

  localparam int unsigned CAND_INVALID = 0;

  localparam int unsigned VOTES_W = 12;
  localparam logic [VOTES_W-1:0] VOTES_MAX = 12'd4095;

  // Saturating increment of the cast-vote counter.
  function automatic logic [VOTES_W-1:0] votes_sat_inc(input logic [VOTES_W-1:0] v);
    return (v == VOTES_MAX) ? v : v + VOTES_W'(1);
  endfunction

endpackage

// File: rtl/booth_vote_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module booth_vote_arbiter_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = (IW+1)'(ptr) + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!any && req[pos[IW-1:0]]) begin
        any                 = 1'b1;
        idx                 = pos[IW-1:0];
        grant[pos[IW-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_vote_arbiter.sv
// Arms voting booths, arbitrates their requests round-robin onto the shared tally
// handshake, and acknowledges, rejects and counts votes.
module booth_vote_arbiter
  import booth_vote_arbiter_pkg::*;
#(
  parameter int unsigned N_BOOTH = 4,
  parameter int unsigned CAND_W  = 4,
  parameter int unsigned TMO     = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        poll_open,
  input  logic [N_BOOTH-1:0]          ballot_issue,
  input  logic [N_BOOTH-1:0]          booth_req,
  input  logic [N_BOOTH*CAND_W-1:0]   booth_cand,
  output logic [N_BOOTH-1:0]          booth_armed,
  output logic [N_BOOTH-1:0]          booth_ack,
  output logic [N_BOOTH-1:0]          booth_rej,
  output logic                        tally_valid,
  output logic [CAND_W-1:0]           tally_cand,
  input  logic                        tally_ready,
  output logic [VOTES_W-1:0]          votes_cast,
  output logic                        busy
);

  localparam int unsigned IW    = $clog2(N_BOOTH);
  localparam int unsigned TMO_W = 8;

  logic [STATE_W-1:0] state, state_nxt;
  logic [IW-1:0]      ptr, ptr_nxt, g, g_nxt, rr_idx;
  logic [N_BOOTH-1:0] elig, rr_grant, g_onehot, hold;
  logic [N_BOOTH-1:0] ack_nxt, rej_fsm_nxt, arm, expire, close_clr, armed_nxt;
  logic               rr_any, tally_valid_nxt, votes_inc;
  logic [CAND_W-1:0]  tally_cand_nxt, cand_sel;
  logic [TMO_W-1:0]   tmo_cnt [N_BOOTH];

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(N_BOOTH - 1)) ? '0 : i + IW'(1);
  endfunction

  assign elig = booth_req & booth_armed & {N_BOOTH{poll_open}};

  booth_vote_arbiter_rr_arbiter #(.N(N_BOOTH)) u_rr_arbiter (
    .req   (elig),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  assign cand_sel = booth_cand[32'(rr_idx) * CAND_W +: CAND_W];
  assign g_onehot = N_BOOTH'(1) << g;

  // The in-flight booth, including the one being granted on this edge.
  assign hold = (state == S_IDLE) ? rr_grant : g_onehot;

  assign arm       = ballot_issue & ~booth_armed & {N_BOOTH{poll_open}};
  assign close_clr = poll_open ? '0 : ~hold;
  assign armed_nxt = (booth_armed & ~ack_nxt & ~expire & ~close_clr) | arm;

  always_comb begin
    state_nxt       = state;
    g_nxt           = g;
    ptr_nxt         = ptr;
    tally_valid_nxt = tally_valid;
    tally_cand_nxt  = tally_cand;
    ack_nxt         = '0;
    rej_fsm_nxt     = '0;
    votes_inc       = 1'b0;
    case (state)
      S_IDLE: begin
        if (rr_any) begin
          g_nxt          = rr_idx;
          tally_cand_nxt = cand_sel;
          if (cand_sel != CAND_W'(CAND_INVALID)) begin
            state_nxt       = S_ISSUE;
            tally_valid_nxt = 1'b1;
          end else begin
            state_nxt   = S_REJ;
            rej_fsm_nxt = rr_grant;
            ptr_nxt     = next_idx(rr_idx);
          end
        end
      end
      S_ISSUE: begin
        if (tally_ready) begin
          state_nxt       = S_ACK;
          tally_valid_nxt = 1'b0;
          ack_nxt         = g_onehot;
          votes_inc       = 1'b1;
          ptr_nxt         = next_idx(g);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      g           <= '0;
      ptr         <= '0;
      tally_valid <= 1'b0;
      tally_cand  <= '0;
      booth_armed <= '0;
      booth_ack   <= '0;
      booth_rej   <= '0;
      votes_cast  <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      g           <= g_nxt;
      ptr         <= ptr_nxt;
      tally_valid <= tally_valid_nxt;
      tally_cand  <= tally_cand_nxt;
      booth_armed <= armed_nxt;
      booth_ack   <= ack_nxt;
      booth_rej   <= rej_fsm_nxt | expire;
      votes_cast  <= votes_inc ? votes_sat_inc(votes_cast) : votes_cast;
      busy        <= (state_nxt != S_IDLE);
    end
  end

  // Per-booth idle timeout; frozen while the booth is in flight.
  for (genvar b = 0; b < N_BOOTH; b++) begin : g_tmo
    assign expire[b] = booth_armed[b] & ~hold[b] & (tmo_cnt[b] == TMO_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        tmo_cnt[b] <= '0;
      end else if (arm[b] | rej_fsm_nxt[b]) begin
        tmo_cnt[b] <= TMO_W'(TMO);
      end else if (booth_armed[b] & ~hold[b] & (tmo_cnt[b] != '0)) begin
        tmo_cnt[b] <= tmo_cnt[b] - TMO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_booth_vote_arbiter.sv
// Directed bench for booth_vote_arbiter with hand-computed expectations.
module tb_booth_vote_arbiter;

  localparam int unsigned TMO = 12;

  logic        clk;
  logic        rst_n;
  logic        poll_open;
  logic [3:0]  ballot_issue;
  logic [3:0]  booth_req;
  logic [15:0] booth_cand;
  logic [3:0]  booth_armed;
  logic [3:0]  booth_ack;
  logic [3:0]  booth_rej;
  logic        tally_valid;
  logic [3:0]  tally_cand;
  logic        tally_ready;
  logic [11:0] votes_cast;
  logic        busy;

  int n_pass;
  int n_total;
  int n_fail;

  booth_vote_arbiter #(.N_BOOTH(4), .CAND_W(4), .TMO(TMO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .poll_open    (poll_open),
    .ballot_issue (ballot_issue),
    .booth_req    (booth_req),
    .booth_cand   (booth_cand),
    .booth_armed  (booth_armed),
    .booth_ack    (booth_ack),
    .booth_rej    (booth_rej),
    .tally_valid  (tally_valid),
    .tally_cand   (tally_cand),
    .tally_ready  (tally_ready),
    .votes_cast   (votes_cast),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    rst_n = 1'b0; poll_open = 1'b0; ballot_issue = '0; booth_req = '0;
    booth_cand = '0; tally_ready = 1'b0;
    #2;
    check("rst_armed", 32'(booth_armed), 32'h0);
    check("rst_valid", 32'(tally_valid), 32'h0);
    check("rst_cand",  32'(tally_cand),  32'h0);
    check("rst_votes", 32'(votes_cast),  32'h0);
    check("rst_busy",  32'(busy),        32'h0);
    check("rst_ackrej", 32'({booth_ack, booth_rej}), 32'h0);
    #10 rst_n = 1'b1;
    cyc(1);

    // Single vote on booth 2
    poll_open = 1'b1; tally_ready = 1'b1;
    booth_cand = {4'h0, 4'h5, 4'h0, 4'h0};
    ballot_issue = 4'b0100;
    cyc(1);
    ballot_issue = '0;
    check("single_armed", 32'(booth_armed), 32'h4);
    booth_req = 4'b0100;
    cyc(1);
    booth_req = '0;
    check("single_valid", 32'(tally_valid), 32'h1);
    check("single_cand",  32'(tally_cand),  32'h5);
    check("single_busy",  32'(busy),        32'h1);
    cyc(1);
    check("single_ack",   32'(booth_ack),   32'h4);
    check("single_vdrop", 32'(tally_valid), 32'h0);
    check("single_disarm", 32'(booth_armed), 32'h0);
    check("single_votes", 32'(votes_cast),  32'h1);
    cyc(1);
    check("single_ack_end", 32'(booth_ack), 32'h0);
    check("single_idle",    32'(busy),      32'h0);

    // Reset returns the pointer to booth 0 and clears the count
    #1 rst_n = 1'b0;
    #1 check("rst2_votes", 32'(votes_cast), 32'h0);
    #2 rst_n = 1'b1;
    cyc(1);

    // Fairness: all four booths armed and requesting
    booth_cand = {4'h4, 4'h3, 4'h2, 4'h1};
    ballot_issue = 4'b1111;
    cyc(1);
    ballot_issue = '0;
    check("fair_armed", 32'(booth_armed), 32'hf);
    booth_req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      cyc(1);
      check($sformatf("fair_cand%0d", k), 32'(tally_cand), 32'(k + 1));
      check($sformatf("fair_valid%0d", k), 32'(tally_valid), 32'h1);
      cyc(1);
      check($sformatf("fair_ack%0d", k), 32'(booth_ack), 32'(1 << k));
      cyc(1);
    end
    check("fair_votes", 32'(votes_cast), 32'h4);
    ballot_issue = 4'b1010;
    cyc(1);
    ballot_issue = '0;
    cyc(1);
    check("fair2_first", 32'(tally_cand), 32'h2);
    cyc(1);
    check("fair2_ack1", 32'(booth_ack), 32'h2);
    cyc(2);
    check("fair2_second", 32'(tally_cand), 32'h4);
    cyc(1);
    check("fair2_ack3", 32'(booth_ack), 32'h8);
    cyc(1);
    check("fair2_votes", 32'(votes_cast), 32'h6);
    booth_req = '0;

    // Invalid candidate code, then a valid retry
    booth_cand = {4'h4, 4'h3, 4'h0, 4'h1};
    ballot_issue = 4'b0010;
    booth_req = 4'b0010;
    cyc(1);
    ballot_issue = '0;
    cyc(1);
    check("inv_rej",   32'(booth_rej),   32'h2);
    check("inv_valid", 32'(tally_valid), 32'h0);
    check("inv_armed", 32'(booth_armed), 32'h2);
    booth_cand = {4'h4, 4'h3, 4'h7, 4'h1};
    cyc(1);
    check("inv_rej_end", 32'(booth_rej), 32'h0);
    cyc(1);
    check("retry_cand", 32'(tally_cand), 32'h7);
    cyc(1);
    check("retry_ack",   32'(booth_ack),  32'h2);
    check("retry_votes", 32'(votes_cast), 32'h7);
    booth_req = '0;
    cyc(1);

    // Backpressure with poll closing mid-transfer
    tally_ready = 1'b0;
    booth_cand = {4'h4, 4'h3, 4'h7, 4'h9};
    ballot_issue = 4'b0101;
    booth_req = 4'b0001;
    cyc(1);
    ballot_issue = '0;
    cyc(1);
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      check($sformatf("bp_valid%0d", i), 32'(tally_valid), 32'h1);
      check($sformatf("bp_cand%0d", i),  32'(tally_cand),  32'h9);
      if (i == 5) poll_open = 1'b0;
    end
    check("bp_armed", 32'(booth_armed), 32'h1);
    check("bp_norej", 32'(booth_rej),   32'h0);
    tally_ready = 1'b1;
    cyc(1);
    check("bp_ack",   32'(booth_ack),   32'h1);
    check("bp_votes", 32'(votes_cast),  32'h8);
    check("bp_disarm", 32'(booth_armed), 32'h0);
    cyc(1);
    poll_open = 1'b1;
    booth_req = '0;

    // Idle timeout on booth 0
    ballot_issue = 4'b0001;
    cyc(1);
    ballot_issue = '0;
    cyc(TMO - 1);
    check("tmo_before_armed", 32'(booth_armed), 32'h1);
    check("tmo_before_rej",   32'(booth_rej),   32'h0);
    cyc(1);
    check("tmo_rej",   32'(booth_rej),   32'h1);
    check("tmo_armed", 32'(booth_armed), 32'h0);
    cyc(1);
    check("tmo_rej_end", 32'(booth_rej), 32'h0);
    booth_req = 4'b0001;
    cyc(2);
    check("tmo_late_valid", 32'(tally_valid), 32'h0);
    check("tmo_late_busy",  32'(busy),        32'h0);
    booth_req = '0;

    // Double ballot to booth 3, and ballot to the granted booth during ISSUE
    ballot_issue = 4'b1000;
    cyc(2);
    ballot_issue = '0;
    booth_req = 4'b1000;
    cyc(1);
    check("dbl_cand", 32'(tally_cand), 32'h4);
    ballot_issue = 4'b1000;
    cyc(1);
    ballot_issue = '0;
    check("dbl_ack", 32'(booth_ack), 32'h8);
    cyc(1);
    check("dbl_disarm", 32'(booth_armed), 32'h0);
    booth_req = 4'b1100;
    cyc(3);
    check("dbl_votes", 32'(votes_cast), 32'h9);
    check("unarmed_ackrej", 32'({booth_ack, booth_rej}), 32'h0);
    check("unarmed_valid", 32'(tally_valid), 32'h0);
    booth_req = '0;

    // Reset while a vote is in ISSUE
    tally_ready = 1'b0;
    ballot_issue = 4'b0010;
    booth_req = 4'b0010;
    cyc(1);
    ballot_issue = '0;
    cyc(1);
    check("rstiss_valid_pre", 32'(tally_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("rstiss_valid", 32'(tally_valid), 32'h0);
    check("rstiss_votes", 32'(votes_cast),  32'h0);
    check("rstiss_armed", 32'(booth_armed), 32'h0);
    check("rstiss_busy",  32'(busy),        32'h0);
    #2 rst_n = 1'b1;
    booth_req = '0;
    cyc(2);
    check("post_rst_valid", 32'(tally_valid), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
